// File: rtl/game_pkg.sv
// Shared definitions for the Triangles-vs-Circles game controller.
// Holds the cell and winner encodings, the controller state enum, the scan
// axis direction table and the default board geometry.
package game_pkg;

  localparam int BOARD_N_DEF = 10;  // board width/height in cells
  localparam int WIN_LEN_DEF = 4;   // pieces in a row needed to win

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_TRI   = 2'b01,
    CELL_CIR   = 2'b10
  } cell_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_TRI  = 2'b01,
    WIN_CIR  = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SCAN,
    ST_RESOLVE,
    ST_DONE
  } state_e;

  // Axis table, scanned in index order:
  // 0 horizontal (+1,0), 1 vertical (0,+1), 2 diagonal (+1,+1),
  // 3 anti-diagonal (+1,-1). Only the positive sense is stored; the
  // negative sense is the negated step.
  function automatic logic signed [1:0] axis_dx(input logic [1:0] axis);
    case (axis)
      2'd0:    axis_dx = 2'sd1;
      2'd1:    axis_dx = 2'sd0;
      2'd2:    axis_dx = 2'sd1;
      default: axis_dx = 2'sd1;
    endcase
  endfunction

  function automatic logic signed [1:0] axis_dy(input logic [1:0] axis);
    case (axis)
      2'd0:    axis_dy = 2'sd0;
      2'd1:    axis_dy = 2'sd1;
      2'd2:    axis_dy = 2'sd1;
      default: axis_dy = -2'sd1;
    endcase
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Bundle of the game controller's non-clock signals.
//   Input-handler side : x_in, y_in, coord_valid, new_game
//   Display side       : rd_x, rd_y (address) -> rd_cell (registered data)
//   Status             : turn, busy, move_accepted, move_rejected,
//                        tri_moves, cir_moves, game_over, winner
// master = the environment driving moves and reading state,
// slave  = the game controller itself.
interface game_controller_if;
  logic [3:0] x_in;
  logic [3:0] y_in;
  logic       coord_valid;
  logic       new_game;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic [1:0] rd_cell;
  logic       turn;
  logic       busy;
  logic       move_accepted;
  logic       move_rejected;
  logic [6:0] tri_moves;
  logic [6:0] cir_moves;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output x_in, y_in, coord_valid, new_game, rd_x, rd_y,
    input  rd_cell, turn, busy, move_accepted, move_rejected,
           tri_moves, cir_moves, game_over, winner
  );

  modport slave (
    input  x_in, y_in, coord_valid, new_game, rd_x, rd_y,
    output rd_cell, turn, busy, move_accepted, move_rejected,
           tri_moves, cir_moves, game_over, winner
  );
endinterface

// File: rtl/board_regfile.sv
// Board occupancy store: BOARD_N*BOARD_N cells of 2 bits each.
// Ports:
//   clk, clr            clock and synchronous clear of every cell and rd_cell
//   we, waddr, wdata    single write port (cell index = y*BOARD_N + x)
//   saddr -> sdata      combinational read port used by the scan logic
//   rd_x, rd_y -> rd_cell  registered display read, 00 when out of range
module board_regfile
  import game_pkg::*;
#(
  parameter int BOARD_N = BOARD_N_DEF,
  localparam int CELLS = BOARD_N * BOARD_N,
  localparam int IDX_W = $clog2(CELLS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [1:0]       wdata,
  input  logic [IDX_W-1:0] saddr,
  output logic [1:0]       sdata,
  input  logic [3:0]       rd_x,
  input  logic [3:0]       rd_y,
  output logic [1:0]       rd_cell
);

  // The scan port needs every cell combinationally, so the store is a
  // register array rather than a block RAM.
  logic [CELLS-1:0][1:0] cells;

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
    localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(gi);
    logic [1:0] cell_q;
    logic [1:0] cell_d;

    always_comb begin
      cell_d = cell_q;
      if (we && (waddr == MY_IDX)) begin
        cell_d = wdata;
      end
    end

    always_ff @(posedge clk) begin
      if (clr) begin
        cell_q <= CELL_EMPTY;
      end else begin
        cell_q <= cell_d;
      end
    end

    assign cells[gi] = cell_q;
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  always_comb begin
    sdata = CELL_EMPTY;
    if (saddr <= LAST_IDX) begin
      sdata = cells[saddr];
    end
  end

  logic             rd_ok;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       rd_cell_d;
  logic [1:0]       rd_cell_q;

  always_comb begin
    rd_ok     = (int'(rd_x) < BOARD_N) && (int'(rd_y) < BOARD_N);
    rd_idx    = IDX_W'(int'(rd_y) * BOARD_N + int'(rd_x));
    rd_cell_d = rd_ok ? cells[rd_idx] : CELL_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_cell_q <= CELL_EMPTY;
    end else begin
      rd_cell_q <= rd_cell_d;
    end
  end

  assign rd_cell = rd_cell_q;

endmodule

// File: rtl/game_controller.sv
// Turn sequencer for Triangles-vs-Circles.
// Takes coordinate strobes, validates the move against the board, places the
// piece, then walks outwards from it along four axes to decide win/draw.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    game_controller_if.slave (moves in, display read, status out)
module game_controller
  import game_pkg::*;
#(
  parameter int BOARD_N = BOARD_N_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input logic              clk,
  input logic              reset,
  game_controller_if.slave bus
);

  localparam int IDX_W = $clog2(BOARD_N * BOARD_N);
  localparam logic [3:0] LAST_STEP = 4'(WIN_LEN - 1);
  localparam logic [3:0] WIN_RUN   = 4'(WIN_LEN);
  localparam logic [7:0] CELLS_N   = 8'(BOARD_N * BOARD_N);

  state_e            state_q, state_d;
  logic              turn_q, turn_d;
  logic [3:0]        x_q, x_d;
  logic [3:0]        y_q, y_d;
  logic              acc_q, acc_d;
  logic              rej_q, rej_d;
  logic [6:0]        tri_q, tri_d;
  logic [6:0]        cir_q, cir_d;
  logic [1:0]        winner_q, winner_d;
  logic              game_over_q, game_over_d;
  logic              busy_q, busy_d;
  logic [1:0]        axis_q, axis_d;
  logic              neg_q, neg_d;    // 0 = walking positive sense
  logic [3:0]        step_q, step_d;  // steps taken in current sense
  logic [3:0]        run_q, run_d;    // matching pieces on current axis
  logic signed [5:0] cx_q, cx_d;      // walk cursor
  logic signed [5:0] cy_q, cy_d;
  logic              win_q, win_d;

  // Board interface
  logic             clr;
  logic             we;
  logic [1:0]       wdata;
  logic [IDX_W-1:0] chk_idx;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] saddr;
  logic [1:0]       sdata;

  // Scan datapath
  logic              in_range;
  logic signed [1:0] dx2, dy2;
  logic signed [5:0] dx6, dy6;
  logic signed [5:0] nx, ny;
  logic              nb_in;
  logic              step_match;
  logic              sense_end;
  logic [3:0]        run_now;
  logic [7:0]        total_moves;

  assign clr = reset || ((state_q == ST_DONE) && bus.new_game);

  board_regfile #(.BOARD_N(BOARD_N)) u_board (
    .clk     (clk),
    .clr     (clr),
    .we      (we),
    .waddr   (chk_idx),
    .wdata   (wdata),
    .saddr   (saddr),
    .sdata   (sdata),
    .rd_x    (bus.rd_x),
    .rd_y    (bus.rd_y),
    .rd_cell (bus.rd_cell)
  );

  // Address generation and neighbour test for the scan walk.
  always_comb begin
    in_range = (int'(x_q) < BOARD_N) && (int'(y_q) < BOARD_N);
    chk_idx  = in_range ? IDX_W'(int'(y_q) * BOARD_N + int'(x_q)) : '0;

    dx2 = axis_dx(axis_q);
    dy2 = axis_dy(axis_q);
    dx6 = {{4{dx2[1]}}, dx2};
    dy6 = {{4{dy2[1]}}, dy2};
    if (neg_q) begin
      dx6 = -dx6;
      dy6 = -dy6;
    end
    nx = cx_q + dx6;
    ny = cy_q + dy6;
    nb_in = (int'(nx) >= 0) && (int'(nx) < BOARD_N) &&
            (int'(ny) >= 0) && (int'(ny) < BOARD_N);
    scan_idx = IDX_W'(int'(ny) * BOARD_N + int'(nx));

    // CHECK looks at the target cell, SCAN at the next neighbour.
    if (state_q == ST_SCAN) begin
      saddr = nb_in ? scan_idx : '0;
    end else begin
      saddr = chk_idx;
    end

    wdata      = turn_q ? CELL_CIR : CELL_TRI;
    step_match = nb_in && (sdata == wdata);
    total_moves = {1'b0, tri_q} + {1'b0, cir_q};
  end

  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = 1'b0;
    rej_d    = 1'b0;
    tri_d    = tri_q;
    cir_d    = cir_q;
    winner_d = winner_q;
    axis_d   = axis_q;
    neg_d    = neg_q;
    step_d   = step_q;
    run_d    = run_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    win_d    = win_q;
    we       = 1'b0;
    sense_end = 1'b0;
    run_now   = run_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.coord_valid) begin
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (!in_range || (sdata != CELL_EMPTY)) begin
          rej_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          we     = 1'b1;
          acc_d  = 1'b1;
          if (turn_q) begin
            cir_d = cir_q + 7'd1;
          end else begin
            tri_d = tri_q + 7'd1;
          end
          run_d   = 4'd1;
          axis_d  = 2'd0;
          neg_d   = 1'b0;
          step_d  = 4'd0;
          win_d   = 1'b0;
          cx_d    = {2'b00, x_q};
          cy_d    = {2'b00, y_q};
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (step_match) begin
          run_now = run_q + 4'd1;
          run_d   = run_now;
          cx_d    = nx;
          cy_d    = ny;
          step_d  = step_q + 4'd1;
          // A sense never looks further than WIN_LEN-1 cells away.
          if ((step_q + 4'd1) == LAST_STEP) begin
            sense_end = 1'b1;
          end
        end else begin
          sense_end = 1'b1;
        end

        if (sense_end) begin
          step_d = 4'd0;
          cx_d   = {2'b00, x_q};
          cy_d   = {2'b00, y_q};
          if (!neg_q) begin
            neg_d = 1'b1;
          end else begin
            // Both senses done: the axis is complete.
            neg_d = 1'b0;
            if (run_now >= WIN_RUN) begin
              win_d   = 1'b1;
              state_d = ST_RESOLVE;
            end else begin
              run_d = 4'd1;
              if (axis_q == 2'd3) begin
                state_d = ST_RESOLVE;
              end else begin
                axis_d = axis_q + 2'd1;
              end
            end
          end
        end
      end

      ST_RESOLVE: begin
        if (win_q) begin
          winner_d = turn_q ? WIN_CIR : WIN_TRI;
          state_d  = ST_DONE;
        end else if (total_moves == CELLS_N) begin
          winner_d = WIN_DRAW;
          state_d  = ST_DONE;
        end else begin
          turn_d  = ~turn_q;
          state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        if (bus.new_game) begin
          state_d  = ST_IDLE;
          turn_d   = 1'b0;
          tri_d    = 7'd0;
          cir_d    = 7'd0;
          winner_d = WIN_NONE;
          win_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags follow the next state so they change with it.
    busy_d      = (state_d != ST_IDLE);
    game_over_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      turn_q      <= 1'b0;
      x_q         <= 4'd0;
      y_q         <= 4'd0;
      acc_q       <= 1'b0;
      rej_q       <= 1'b0;
      tri_q       <= 7'd0;
      cir_q       <= 7'd0;
      winner_q    <= WIN_NONE;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
      axis_q      <= 2'd0;
      neg_q       <= 1'b0;
      step_q      <= 4'd0;
      run_q       <= 4'd0;
      cx_q        <= 6'sd0;
      cy_q        <= 6'sd0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      rej_q       <= rej_d;
      tri_q       <= tri_d;
      cir_q       <= cir_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      busy_q      <= busy_d;
      axis_q      <= axis_d;
      neg_q       <= neg_d;
      step_q      <= step_d;
      run_q       <= run_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      win_q       <= win_d;
    end
  end

  assign bus.turn          = turn_q;
  assign bus.busy          = busy_q;
  assign bus.move_accepted = acc_q;
  assign bus.move_rejected = rej_q;
  assign bus.tri_moves     = tri_q;
  assign bus.cir_moves     = cir_q;
  assign bus.game_over     = game_over_q;
  assign bus.winner        = winner_q;

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;
  import game_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_controller_if bus ();

  game_controller #(.BOARD_N(10), .WIN_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Strobe one coordinate and follow it: returns the pulses seen in cycle t+2
  // and checks they are absent in t+1 and t+3, then waits for the FSM to settle.
  task automatic do_move(input logic [3:0] x, input logic [3:0] y,
                         output logic acc, output logic rej);
    @(negedge clk);
    bus.x_in = x;
    bus.y_in = y;
    bus.coord_valid = 1'b1;
    @(negedge clk);              // cycle t+1
    bus.coord_valid = 1'b0;
    check("pulse_t1", {30'd0, bus.move_accepted, bus.move_rejected}, 0);
    check("busy_t1", bus.busy, 1);
    @(negedge clk);              // cycle t+2
    acc = bus.move_accepted;
    rej = bus.move_rejected;
    @(negedge clk);              // cycle t+3
    check("pulse_t3", {30'd0, bus.move_accepted, bus.move_rejected}, 0);
    for (int i = 0; i < 60 && bus.busy && !bus.game_over; i++) @(negedge clk);
    check("settle_timeout", bus.busy && !bus.game_over, 0);
    $display("move (%0d,%0d) acc=%0d rej=%0d turn=%0d tri=%0d cir=%0d winner=%0d",
             x, y, acc, rej, bus.turn, bus.tri_moves, bus.cir_moves, bus.winner);
  endtask

  task automatic read_cell(input logic [3:0] x, input logic [3:0] y, output logic [1:0] c);
    @(negedge clk);
    bus.rd_x = x;
    bus.rd_y = y;
    @(negedge clk);
    c = bus.rd_cell;
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    $display("new_game issued");
  endtask

  task automatic count_nonempty(output int n);
    logic [1:0] c;
    n = 0;
    for (int yy = 0; yy < 10; yy++)
      for (int xx = 0; xx < 10; xx++) begin
        read_cell(4'(xx), 4'(yy), c);
        if (c !== 2'b00) n++;
      end
  endtask

  typedef struct {
    logic       newg;
    logic [3:0] x;
    logic [3:0] y;
    logic       exp_acc;
    logic       exp_rej;
    logic       exp_turn;
    logic [1:0] exp_win;
  } vec_t;

  vec_t vecs[19];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, rej;
    logic [1:0] c;
    int n;
    logic [3:0] tri_x[$], tri_y[$], cir_x[$], cir_y[$];

    // newg, x, y, acc, rej, turn after, winner after
    vecs[0]  = '{1'b0, 4'd3,  4'd4, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[1]  = '{1'b0, 4'd3,  4'd4, 1'b0, 1'b1, 1'b1, 2'b00}; // occupied
    vecs[2]  = '{1'b0, 4'd10, 4'd2, 1'b0, 1'b1, 1'b1, 2'b00}; // x out of range
    vecs[3]  = '{1'b0, 4'd9,  4'd9, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[5]  = '{1'b0, 4'd9,  4'd8, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 4'd1,  4'd0, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[7]  = '{1'b0, 4'd9,  4'd7, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[8]  = '{1'b0, 4'd2,  4'd0, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[9]  = '{1'b0, 4'd0,  4'd9, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[10] = '{1'b0, 4'd3,  4'd0, 1'b1, 1'b0, 1'b0, 2'b01}; // horizontal win
    vecs[11] = '{1'b0, 4'd5,  4'd0, 1'b0, 1'b0, 1'b0, 2'b01}; // dropped in DONE
    vecs[12] = '{1'b1, 4'd5,  4'd5, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[13] = '{1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[14] = '{1'b0, 4'd4,  4'd6, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[15] = '{1'b0, 4'd0,  4'd1, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[16] = '{1'b0, 4'd7,  4'd3, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[17] = '{1'b0, 4'd0,  4'd2, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[18] = '{1'b0, 4'd6,  4'd4, 1'b1, 1'b0, 1'b0, 2'b01}; // anti-diag win, middle piece

    bus.x_in = 0; bus.y_in = 0; bus.coord_valid = 0; bus.new_game = 0;
    bus.rd_x = 0; bus.rd_y = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_turn", bus.turn, 0);
    check("rst_pulses", {30'd0, bus.move_accepted, bus.move_rejected}, 0);
    check("rst_tri", bus.tri_moves, 0);
    check("rst_cir", bus.cir_moves, 0);
    check("rst_game_over", bus.game_over, 0);
    check("rst_winner", bus.winner, 0);
    check("rst_rd_cell", bus.rd_cell, 0);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].newg) begin
        pulse_new_game();
        check("ng_game_over", bus.game_over, 0);
        check("ng_winner", bus.winner, 0);
        check("ng_tri", bus.tri_moves, 0);
        read_cell(4'd3, 4'd0, c);
        check("ng_cell_3_0", c, 0);
      end
      do_move(vecs[i].x, vecs[i].y, acc, rej);
      check($sformatf("v%0d_acc", i), acc, vecs[i].exp_acc);
      check($sformatf("v%0d_rej", i), rej, vecs[i].exp_rej);
      check($sformatf("v%0d_turn", i), bus.turn, vecs[i].exp_turn);
      check($sformatf("v%0d_winner", i), bus.winner, vecs[i].exp_win);
      check($sformatf("v%0d_game_over", i), bus.game_over, vecs[i].exp_win != 2'b00);
      if (i == 0) begin
        check("v0_tri", bus.tri_moves, 1);
        read_cell(4'd3, 4'd4, c);
        check("v0_cell_3_4", c, 1);
      end
      if (i == 1) begin
        check("v1_cir", bus.cir_moves, 0);
        read_cell(4'd3, 4'd4, c);
        check("v1_cell_3_4", c, 1);
      end
      if (i == 11) begin
        check("v11_tri", bus.tri_moves, 5);
        check("v11_cir", bus.cir_moves, 4);
        read_cell(4'd5, 4'd0, c);
        check("v11_cell_5_0", c, 0);
      end
    end

    // Draw: cell (x,y) belongs to triangle when ((x+2y)>>1) is even.
    // Every line in every direction alternates in runs of at most two.
    pulse_new_game();
    for (int yy = 0; yy < 10; yy++)
      for (int xx = 0; xx < 10; xx++) begin
        if ((((xx + 2 * yy) >> 1) & 1) == 0) begin
          tri_x.push_back(4'(xx)); tri_y.push_back(4'(yy));
        end else begin
          cir_x.push_back(4'(xx)); cir_y.push_back(4'(yy));
        end
      end
    check("draw_split", tri_x.size(), 50);
    for (int k = 0; k < 50; k++) begin
      do_move(tri_x[k], tri_y[k], acc, rej);
      check($sformatf("draw_tri%0d_acc", k), acc, 1);
      do_move(cir_x[k], cir_y[k], acc, rej);
      check($sformatf("draw_cir%0d_acc", k), acc, 1);
    end
    check("draw_winner", bus.winner, 3);
    check("draw_game_over", bus.game_over, 1);
    check("draw_tri", bus.tri_moves, 50);
    check("draw_cir", bus.cir_moves, 50);
    read_cell(4'd12, 4'd3, c);
    check("rd_out_of_range", c, 0);
    read_cell(4'd2, 4'd0, c);
    check("draw_cell_2_0", c, 2);

    pulse_new_game();
    check("ng2_turn", bus.turn, 0);
    check("ng2_winner", bus.winner, 0);
    count_nonempty(n);
    check("ng2_board_empty", n, 0);

    // Reset asserted while the FSM is scanning.
    @(negedge clk);
    bus.x_in = 4'd4; bus.y_in = 4'd4; bus.coord_valid = 1'b1;
    @(negedge clk);
    bus.coord_valid = 1'b0;
    @(negedge clk);              // t+2
    check("rs_acc", bus.move_accepted, 1);
    bus.rd_x = 4'd4; bus.rd_y = 4'd4;
    @(negedge clk);              // t+3, scanning
    check("rs_busy_scan", bus.busy, 1);
    check("rs_cell_written", bus.rd_cell, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rs_busy", bus.busy, 0);
    check("rs_turn", bus.turn, 0);
    check("rs_tri", bus.tri_moves, 0);
    check("rs_pulses", {30'd0, bus.move_accepted, bus.move_rejected}, 0);
    check("rs_winner", bus.winner, 0);
    check("rs_game_over", bus.game_over, 0);
    check("rs_rd_cell", bus.rd_cell, 0);
    count_nonempty(n);
    check("rs_board_empty", n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
